// File: rtl/exe_sched_pkg.sv
// exe_sched_pkg -- shared types for the execution scheduler.
//   t_nuke_pkt      : pipeline flush request
//   t_prf_wr_pkt    : PRF writeback (pdst + 64-bit data)
//   t_iss_pkt       : uop handed to EXE at issue
//   t_rs_alloc_pkt  : uop presented by rename for allocation
//   t_rs_entry      : one scheduler entry (valid + stored uop)
//   RS_NUM_ENTRIES  : default scheduler depth
//   wake_hit()      : writeback-matches-waiting-source test
// Optional feature macro used elsewhere: SCHED_PERF_EN.
package exe_sched_pkg;

  localparam int RS_NUM_ENTRIES = 8;
  localparam int PREG_W         = 7;
  localparam int ROB_W          = 6;
  localparam int UINSTR_W       = 32;
  localparam int DATA_W         = 64;

  typedef struct packed {
    logic valid;
  } t_nuke_pkt;

  typedef struct packed {
    logic [PREG_W-1:0] pdst;
    logic [DATA_W-1:0] data;
  } t_prf_wr_pkt;

  typedef struct packed {
    logic [UINSTR_W-1:0] uinstr;
    logic [ROB_W-1:0]    robid;
    logic [PREG_W-1:0]   pdst;
    logic [DATA_W-1:0]   src1_val;
    logic [DATA_W-1:0]   src2_val;
  } t_iss_pkt;

  typedef struct packed {
    logic [UINSTR_W-1:0] uinstr;
    logic [ROB_W-1:0]    robid;
    logic [PREG_W-1:0]   pdst;
    logic [PREG_W-1:0]   psrc1;
    logic [PREG_W-1:0]   psrc2;
    logic                src1_rdy;
    logic                src2_rdy;
    logic [DATA_W-1:0]   src1_val;
    logic [DATA_W-1:0]   src2_val;
  } t_rs_alloc_pkt;

  typedef struct packed {
    logic          valid;
    t_rs_alloc_pkt uop;
  } t_rs_entry;

  // A writeback wakes a source only if that source is still waiting on the same preg.
  function automatic logic wake_hit(input logic              wr_en,
                                    input logic [PREG_W-1:0] wr_pdst,
                                    input logic [PREG_W-1:0] psrc,
                                    input logic              rdy);
    return wr_en & ~rdy & (wr_pdst == psrc);
  endfunction

endpackage

// File: rtl/exe_sched_if.sv
// exe_sched_if -- rename/PRF/EXE-facing bus of the scheduler.
//   nuke_rb1, alloc_valid, alloc_pkt, iprf_wr_en_ex1, iprf_wr_pkt_ex1 : into scheduler
//   alloc_ready, iss_ex0, iss_pkt_ex0, occupancy                      : out of scheduler
// slave modport = scheduler side, master modport = environment side.
interface exe_sched_if import exe_sched_pkg::*; #(
  parameter int NUM_ENTRIES = RS_NUM_ENTRIES
) ();

  t_nuke_pkt                       nuke_rb1;
  logic                            alloc_valid;
  t_rs_alloc_pkt                   alloc_pkt;
  logic                            alloc_ready;
  logic                            iprf_wr_en_ex1;
  t_prf_wr_pkt                     iprf_wr_pkt_ex1;
  logic                            iss_ex0;
  t_iss_pkt                        iss_pkt_ex0;
  logic [$clog2(NUM_ENTRIES):0]    occupancy;

  modport slave (
    input  nuke_rb1, alloc_valid, alloc_pkt, iprf_wr_en_ex1, iprf_wr_pkt_ex1,
    output alloc_ready, iss_ex0, iss_pkt_ex0, occupancy
  );

  modport master (
    output nuke_rb1, alloc_valid, alloc_pkt, iprf_wr_en_ex1, iprf_wr_pkt_ex1,
    input  alloc_ready, iss_ex0, iss_pkt_ex0, occupancy
  );

endinterface

// File: rtl/exe_sched_chk.sv
// exe_sched_chk -- protocol/invariant assertions for exe_sched.
//   alloc_valid/alloc_ready/nuke_valid : allocation handshake
//   valid_vec, grant_vec, robid_vec    : entry state and select result
module exe_sched_chk import exe_sched_pkg::*; #(
  parameter int N = RS_NUM_ENTRIES
) (
  input logic             clk,
  input logic             reset,
  input logic             alloc_valid,
  input logic             alloc_ready,
  input logic             nuke_valid,
  input logic [N-1:0]     valid_vec,
  input logic [N-1:0]     grant_vec,
  input logic [ROB_W-1:0] robid_vec [N]
);

  logic dup_robid_s;

  // Flags any pair of live entries carrying the same ROB id.
  always_comb begin
    dup_robid_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int j = i + 1; j < N; j++) begin
        dup_robid_s = dup_robid_s | (valid_vec[i] & valid_vec[j] & (robid_vec[i] == robid_vec[j]));
      end
    end
  end

  a_alloc_when_full: assert property (@(posedge clk) disable iff (!reset)
    !(alloc_valid && !alloc_ready && !nuke_valid));

  a_one_select: assert property (@(posedge clk) disable iff (!reset)
    $onehot0(grant_vec));

  a_unique_robid: assert property (@(posedge clk) disable iff (!reset)
    !dup_robid_s);

endmodule

// File: rtl/exe_sched_rs_age_matrix.sv
// rs_age_matrix -- NxN relative-age tracker for the scheduler entries.
//   clk, reset    : clock, async active-low reset
//   alloc_oh      : one-hot entry being allocated this cycle (zero if none)
//   dealloc_vec   : entries leaving this cycle
//   flush         : drop all age relations
//   valid_vec     : entries currently valid
//   req_vec       : candidates for selection
//   oldest_oh     : one-hot oldest candidate (zero if no candidate)
// older_r[i][j] = 1 means entry j was allocated before entry i and is still live.
module rs_age_matrix #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] alloc_oh,
  input  logic [N-1:0] dealloc_vec,
  input  logic         flush,
  input  logic [N-1:0] valid_vec,
  input  logic [N-1:0] req_vec,
  output logic [N-1:0] oldest_oh
);

  logic [N-1:0] older_r [N];

  // Row set on allocation; a leaving entry's column is cleared so it stops blocking others.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) older_r[i] <= {N{1'b0}};
    end else if (flush) begin
      for (int i = 0; i < N; i++) older_r[i] <= {N{1'b0}};
    end else begin
      for (int i = 0; i < N; i++) begin
        if (alloc_oh[i]) older_r[i] <= valid_vec & ~dealloc_vec;
        else             older_r[i] <= older_r[i] & ~dealloc_vec;
      end
    end
  end

  // A requester wins when no older live entry is also requesting.
  always_comb begin
    oldest_oh = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      oldest_oh[i] = req_vec[i] & ~(|(older_r[i] & req_vec));
    end
  end

endmodule

// File: rtl/exe_sched.sv
// exe_sched -- single-issue out-of-order reservation station.
//   clk, reset : clock, async active-low reset
//   bus        : exe_sched_if.slave (alloc, PRF writeback wakeup, nuke, issue, occupancy)
//   perf_issue_cnt, perf_full_cnt : present only with SCHED_PERF_EN defined
// Allocation goes to the lowest free index; issue picks the oldest ready entry
// via rs_age_matrix, so index order and age order are independent.
module exe_sched import exe_sched_pkg::*; #(
  parameter int NUM_ENTRIES = RS_NUM_ENTRIES
) (
  input  logic        clk,
  input  logic        reset,
  exe_sched_if.slave  bus
`ifdef SCHED_PERF_EN
  ,
  output logic [31:0] perf_issue_cnt,
  output logic [31:0] perf_full_cnt
`endif
);

  localparam int CNT_W = $clog2(NUM_ENTRIES) + 1;

  t_rs_entry            entries_r [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] valid_s;
  logic [NUM_ENTRIES-1:0] ready_s;
  logic [NUM_ENTRIES-1:0] free_oh_s;
  logic [NUM_ENTRIES-1:0] grant_s;
  logic [NUM_ENTRIES-1:0] dealloc_s;
  logic [NUM_ENTRIES-1:0] alloc_oh_s;
  logic [ROB_W-1:0]     robid_s [NUM_ENTRIES];
  logic                 free_seen_s;
  logic                 alloc_ready_s;
  logic                 alloc_fire_s;
  logic                 iss_s;
  t_rs_alloc_pkt        alloc_uop_s;
  t_iss_pkt             iss_pkt_s;
  t_iss_pkt             cand_s;
  logic [CNT_W-1:0]     occ_s;

  // Per-entry status vectors.
  always_comb begin
    valid_s = {NUM_ENTRIES{1'b0}};
    ready_s = {NUM_ENTRIES{1'b0}};
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      valid_s[i] = entries_r[i].valid;
      ready_s[i] = entries_r[i].valid & entries_r[i].uop.src1_rdy & entries_r[i].uop.src2_rdy;
      robid_s[i] = entries_r[i].uop.robid;
    end
  end

  // Lowest-index free slot; a slot freed by this cycle's issue is not reused this cycle.
  always_comb begin
    free_oh_s   = {NUM_ENTRIES{1'b0}};
    free_seen_s = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      free_oh_s[i] = ~valid_s[i] & ~free_seen_s;
      free_seen_s  = free_seen_s | ~valid_s[i];
    end
  end

  assign alloc_ready_s = ~(&valid_s);
  assign alloc_fire_s  = bus.alloc_valid & alloc_ready_s & ~bus.nuke_rb1.valid;
  assign alloc_oh_s    = alloc_fire_s ? free_oh_s : {NUM_ENTRIES{1'b0}};

  // Same-cycle writeback bypass into the allocating uop.
  always_comb begin
    alloc_uop_s = bus.alloc_pkt;
    if (wake_hit(bus.iprf_wr_en_ex1, bus.iprf_wr_pkt_ex1.pdst, bus.alloc_pkt.psrc1, bus.alloc_pkt.src1_rdy)) begin
      alloc_uop_s.src1_rdy = 1'b1;
      alloc_uop_s.src1_val = bus.iprf_wr_pkt_ex1.data;
    end else begin
      alloc_uop_s.src1_rdy = bus.alloc_pkt.src1_rdy;
    end
    if (wake_hit(bus.iprf_wr_en_ex1, bus.iprf_wr_pkt_ex1.pdst, bus.alloc_pkt.psrc2, bus.alloc_pkt.src2_rdy)) begin
      alloc_uop_s.src2_rdy = 1'b1;
      alloc_uop_s.src2_val = bus.iprf_wr_pkt_ex1.data;
    end else begin
      alloc_uop_s.src2_rdy = bus.alloc_pkt.src2_rdy;
    end
  end

  rs_age_matrix #(.N(NUM_ENTRIES)) u_age (
    .clk         (clk),
    .reset       (reset),
    .alloc_oh    (alloc_oh_s),
    .dealloc_vec (dealloc_s),
    .flush       (bus.nuke_rb1.valid),
    .valid_vec   (valid_s),
    .req_vec     (ready_s),
    .oldest_oh   (grant_s)
  );

  // Issue select and one-hot AND-OR mux of the granted entry; all zeros when idle.
  always_comb begin
    iss_s     = (|ready_s) & ~bus.nuke_rb1.valid;
    dealloc_s = iss_s ? grant_s : {NUM_ENTRIES{1'b0}};
    iss_pkt_s = {$bits(t_iss_pkt){1'b0}};
    cand_s    = {$bits(t_iss_pkt){1'b0}};
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      cand_s.uinstr   = entries_r[i].uop.uinstr;
      cand_s.robid    = entries_r[i].uop.robid;
      cand_s.pdst     = entries_r[i].uop.pdst;
      cand_s.src1_val = entries_r[i].uop.src1_val;
      cand_s.src2_val = entries_r[i].uop.src2_val;
      iss_pkt_s = iss_pkt_s | (cand_s & {$bits(t_iss_pkt){dealloc_s[i]}});
    end
  end

  // Popcount of valid bits.
  always_comb begin
    occ_s = {CNT_W{1'b0}};
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      occ_s = occ_s + {{(CNT_W-1){1'b0}}, valid_s[i]};
    end
  end

  // Entry state: nuke beats alloc beats issue beats wakeup.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) entries_r[i] <= {$bits(t_rs_entry){1'b0}};
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (bus.nuke_rb1.valid) begin
          entries_r[i].valid <= 1'b0;
        end else if (alloc_oh_s[i]) begin
          entries_r[i].valid <= 1'b1;
          entries_r[i].uop   <= alloc_uop_s;
        end else if (dealloc_s[i]) begin
          entries_r[i].valid <= 1'b0;
        end else if (entries_r[i].valid) begin
          if (wake_hit(bus.iprf_wr_en_ex1, bus.iprf_wr_pkt_ex1.pdst,
                       entries_r[i].uop.psrc1, entries_r[i].uop.src1_rdy)) begin
            entries_r[i].uop.src1_rdy <= 1'b1;
            entries_r[i].uop.src1_val <= bus.iprf_wr_pkt_ex1.data;
          end
          if (wake_hit(bus.iprf_wr_en_ex1, bus.iprf_wr_pkt_ex1.pdst,
                       entries_r[i].uop.psrc2, entries_r[i].uop.src2_rdy)) begin
            entries_r[i].uop.src2_rdy <= 1'b1;
            entries_r[i].uop.src2_val <= bus.iprf_wr_pkt_ex1.data;
          end
        end
      end
    end
  end

  assign bus.alloc_ready = alloc_ready_s;
  assign bus.iss_ex0     = iss_s;
  assign bus.iss_pkt_ex0 = iss_pkt_s;
  assign bus.occupancy   = occ_s;

`ifdef SCHED_PERF_EN
  logic [31:0] perf_issue_cnt_r;
  logic [31:0] perf_full_cnt_r;

  // Free-running event counters; they wrap at 32 bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_issue_cnt_r <= 32'd0;
      perf_full_cnt_r  <= 32'd0;
    end else begin
      if (iss_s) perf_issue_cnt_r <= perf_issue_cnt_r + 32'd1;
      if (bus.alloc_valid && !alloc_ready_s) perf_full_cnt_r <= perf_full_cnt_r + 32'd1;
    end
  end

  assign perf_issue_cnt = perf_issue_cnt_r;
  assign perf_full_cnt  = perf_full_cnt_r;
`endif

  exe_sched_chk #(.N(NUM_ENTRIES)) u_chk (
    .clk         (clk),
    .reset       (reset),
    .alloc_valid (bus.alloc_valid),
    .alloc_ready (alloc_ready_s),
    .nuke_valid  (bus.nuke_rb1.valid),
    .valid_vec   (valid_s),
    .grant_vec   (grant_s),
    .robid_vec   (robid_s)
  );

endmodule

// File: doc/exe_sched.md
EXE_SCHED -- requirements
Module: exe_sched

Interface
REQ-001 Parameter: NUM_ENTRIES, default 8, number of scheduler entries (power of two, 2..16).
REQ-002 clk  input  1  core clock; all state on posedge.
REQ-003 reset  input  1  asynchronous, active-low reset (low = in reset).
REQ-004 nuke_rb1  input  t_nuke_pkt  pipeline nuke; .valid flushes all entries.
REQ-005 alloc_valid  input  1  rename presents a uop for allocation.
REQ-006 alloc_pkt  input  t_rs_alloc_pkt  uinstr, robid, pdst, psrc1/psrc2, src1_rdy/src2_rdy, src1_val/src2_val.
REQ-007 alloc_ready  output  1  at least one free entry.
REQ-008 iprf_wr_en_ex1  input  1  PRF writeback strobe; used as wakeup plus data capture.
REQ-009 iprf_wr_pkt_ex1  input  t_prf_wr_pkt  writeback pdst and data.
REQ-010 iss_ex0  output  1  uop issued to EXE this cycle.
REQ-011 iss_pkt_ex0  output  t_iss_pkt  uinstr, robid, pdst, src1_val, src2_val of the issued uop.
REQ-012 occupancy  output  $clog2(NUM_ENTRIES)+1  count of valid entries.

Function
REQ-013 Allocation: alloc_valid & alloc_ready & !nuke_rb1.valid writes alloc_pkt into the lowest-index free entry at the next posedge.
REQ-014 alloc_ready = !(all entries valid); issue and allocation in the same cycle do not free a slot for that cycle's allocation.
REQ-015 Each entry holds per-source ready bits and 64-bit captured values; a source is ready once its value is captured.
REQ-016 Wakeup: iprf_wr_en_ex1 with pdst equal to a not-ready psrc of a valid entry sets that ready bit and captures data at the posedge.
REQ-017 Wakeup bypass: an allocating source that is not ready, whose psrc matches the same-cycle iprf_wr_pkt_ex1.pdst, is written ready with the writeback data.
REQ-018 Select is combinational: iss_ex0 = 1 when any valid entry has both sources ready and nuke_rb1.valid = 0.
REQ-019 The selected entry is the oldest ready entry by allocation order, independent of index.
REQ-020 The issued entry is invalidated at the posedge; the earliest issue is the cycle after allocation, and after wakeup for a waiting entry.
REQ-021 When iss_ex0 = 0, iss_pkt_ex0 is driven to all zeros.
REQ-022 EXE accepts one uop every cycle; there is no stall input.
REQ-023 Nuke: nuke_rb1.valid invalidates every entry at the posedge, suppresses iss_ex0 that cycle, and drops any same-cycle allocation.
REQ-024 occupancy equals the popcount of entry valid bits and never exceeds NUM_ENTRIES.
REQ-025 Assertions (ASSERT): no alloc_valid while !alloc_ready and !nuke_rb1.valid; at most one entry is selected; no two valid entries share robid.

Reset
REQ-026 While reset is low: all entries are invalid, the age state is cleared, alloc_ready = 1, iss_ex0 = 0, iss_pkt_ex0 = 0, occupancy = 0.
REQ-027 Reset asserted mid-operation discards all entries immediately; the first allocation is accepted in the cycle after reset deasserts.

Configuration
REQ-028 With SCHED_PERF_EN defined: outputs perf_issue_cnt (32 bits, increments per iss_ex0) and perf_full_cnt (32 bits, increments per cycle with alloc_valid & !alloc_ready); both wrap, and both reset to 0.
REQ-029 Without SCHED_PERF_EN: the perf ports and counters are absent, with no other behaviour change.

Structure
REQ-030 The shared package (common) holds t_rs_alloc_pkt, t_rs_entry and RS_NUM_ENTRIES; t_iss_pkt, t_prf_wr_pkt and t_nuke_pkt are reused unchanged.
REQ-031 Sub-module rs_age_matrix holds an NxN age matrix: set row on alloc, clear column on dealloc or nuke, and output a one-hot oldest-of-request-vector.

Verification
REQ-032 Alloc robid 3, both sources ready, values 0x11 and 0x22 -> iss_ex0 high the next cycle with src1_val 0x11 and src2_val 0x22, then occupancy 0.
REQ-033 Alloc A (psrc1 = 7, not ready) then B (ready) -> B issues first; a writeback pdst 7 with data 0xBEEF -> A issues the next cycle with src1_val 0xBEEF.
REQ-034 Alloc with psrc2 = 9 not ready, with a same-cycle writeback pdst 9 carrying 0x5 -> issue the next cycle with src2_val 0x5.
REQ-035 Fill 8 entries with sources not ready -> alloc_ready 0, occupancy 8; wake one -> it issues, and alloc_ready is 1 the following cycle.
REQ-036 Four entries ready, then nuke_rb1.valid with a same-cycle alloc -> iss_ex0 0 that cycle, occupancy 0 the next cycle, alloc dropped.
REQ-037 Reset asserted low while 3 entries are valid -> outputs at reset values immediately; with SCHED_PERF_EN, the counters read 0.
